threshold2_mul_arb: RTL and testbench
=====================================

THRESHOLD2_MUL_ARB -- requirements
Module: threshold2_mul_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter A_W, default 20, meaning the operand A width.
REQ-003 SHALL have parameter B_W, default 8, meaning the operand B width.
REQ-004 SHALL have parameter P_W, default 28 (=A_W+B_W), meaning the product width.
REQ-005 ap_clk  in  1  the single clock; all logic is rising-edge.
REQ-006 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  NREQ  per-requester operand valid.
REQ-008 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-009 req_a  in  NREQ*A_W  packed operand A; requester i occupies bits [i*A_W +: A_W].
REQ-010 req_b  in  NREQ*B_W  packed operand B; requester i occupies bits [i*B_W +: B_W].
REQ-011 rsp_valid  out  1  product valid.
REQ-012 rsp_ready  in  1  product consumer accept.
REQ-013 rsp_p  out  P_W  unsigned product.
REQ-014 rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_p.
REQ-015 inflight  out  2  number of valid operations in the pipeline (0..2).

Function
REQ-016 SHALL share one two-stage unsigned multiplier among NREQ requesters: stage 1 registers a/b, stage 2 registers the product, and both stages share one clock-enable ce.
REQ-017 SHALL set ce = !(v2 && !rsp_ready), where v1/v2 are the stage valid bits; the pipeline advances only when ce=1.
REQ-018 SHALL choose the grant round-robin: the search starts at ptr, the lowest index at or after ptr (wrapping) with req_valid high wins.
REQ-019 SHALL assert req_ready[g] only when ce=1 and requester g is granted; a transfer is req_valid[g] && req_ready[g].
REQ-020 SHALL update ptr to (g+1) mod NREQ after each transfer, and leave ptr unchanged otherwise.
REQ-021 SHALL, when ce=1, load v1 with the transfer flag and id1 with g, and shift v1->v2 and id1->id2; a bubble (no transfer) loads v1=0.
REQ-022 SHALL produce latency 2: a transfer in cycle T presents rsp_valid=1 in cycle T+2 if no stall intervenes; throughput is 1 operation per cycle.
REQ-023 SHALL drive rsp_valid=v2, rsp_id=id2, and rsp_p = A*B at full P_W width with no truncation.
REQ-024 SHALL hold rsp_p, rsp_id and rsp_valid stable while rsp_valid=1 and rsp_ready=0, and SHALL assert no req_ready in that state.
REQ-025 SHALL let a stalled pipeline with v2=0 still advance; backpressure applies only when the output is occupied.
REQ-026 SHALL drive inflight = v1+v2.
REQ-027 SHALL forward req_a/req_b unchanged when a requester drops req_valid without a transfer (no state captured).

Reset
REQ-028 SHALL, while ap_rst_n=0, force v1=v2=0, ptr=0, id1=id2=0, rsp_valid=0, req_ready=0 and inflight=0; rsp_p is don't-care but SHALL NOT be X-dependent for rsp_valid.
REQ-029 SHALL discard in-flight operations on reset mid-operation and produce no response for them after release.
REQ-030 SHALL allow the first grant in the first cycle after ap_rst_n rises.

Structure
REQ-031 SHALL place default widths, NREQ and the ID width constant in a shared package threshold2_mul_pkg.
REQ-032 SHALL implement the multiplier datapath as sub-module threshold2_mul_pipe (ports: clk, ce, a, b, p; two stages; no reset on data).
REQ-033 SHALL keep the arbiter, valid/id shift chain and ptr in the top module, targeting 120-400 lines of RTL in total.

Verification
REQ-034 Single requester: req_valid=0001, a=1000, b=200 in cycle T -> rsp_valid in T+2, rsp_p=200000, rsp_id=0, inflight=1 in T+1.
REQ-035 Max operands: a=0xFFFFF, b=0xFF -> rsp_p=0xFEFFF01, no truncation.
REQ-036 All four requesters held valid, rsp_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3 and back-to-back rsp_valid with matching ids.
REQ-037 Backpressure: rsp_ready=0 for 3 cycles with v2=1 -> rsp_p/rsp_id stable, req_ready=0, inflight=2; on release, outputs drain in order with no loss or duplication.
REQ-038 Reset mid-operation: ap_rst_n low for 1 cycle with inflight=2 -> all outputs 0, no stale response afterwards, next grant goes to requester 0.
REQ-039 Random valid/ready for 10k cycles against a scoreboard -> every accepted operation returns exactly once, in order, with the correct product and id, and no requester starves beyond NREQ grants.

Source files
------------

// File: rtl/threshold2_mul_pkg.sv
// Shared defaults for the round-robin arbiter in front of a shared two-stage multiplier.
package threshold2_mul_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned A_W_DEF  = 20;
  localparam int unsigned B_W_DEF  = 8;
  localparam int unsigned P_W_DEF  = A_W_DEF + B_W_DEF;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/threshold2_mul_pipe.sv
// Two-stage unsigned multiplier: operand registers, then product register, one shared enable.
module threshold2_mul_pipe
  import threshold2_mul_pkg::*;
#(
  parameter int unsigned A_W = A_W_DEF,
  parameter int unsigned B_W = B_W_DEF,
  parameter int unsigned P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q;
  logic [P_W-1:0] p_q;

  // Data path carries no reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_q <= a;
      b_q <= b;
      p_q <= P_W'(a_q) * P_W'(b_q);
    end
  end

  assign p = p_q;

endmodule

// File: rtl/threshold2_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ requesters.
module threshold2_mul_arb
  import threshold2_mul_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned A_W  = A_W_DEF,
  parameter int unsigned B_W  = B_W_DEF,
  parameter int unsigned P_W  = A_W + B_W,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [P_W-1:0]    rsp_p,
  output logic [ID_W-1:0]   rsp_id,
  output logic [1:0]        inflight
);

  logic            v1_q, v2_q;
  logic [ID_W-1:0] id1_q, id2_q, ptr_q;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            ce;
  logic            xfer;
  logic [A_W-1:0]  sel_a;
  logic [B_W-1:0]  sel_b;

  // Stall only when the output register holds an unaccepted product.
  assign ce = !(v2_q && !rsp_ready);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = k + 32'(ptr_q);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[ID_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Reset level gates the handshake so nothing is accepted while held in reset.
  assign xfer = ap_rst_n && ce && gnt_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  assign sel_a = req_a[gnt_id*A_W +: A_W];
  assign sel_b = req_b[gnt_id*B_W +: B_W];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      id1_q <= '0;
      id2_q <= '0;
      ptr_q <= '0;
    end else if (ce) begin
      v1_q  <= xfer;
      id1_q <= gnt_id;
      v2_q  <= v1_q;
      id2_q <= id1_q;
      if (xfer) ptr_q <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  threshold2_mul_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_pipe (
    .clk (ap_clk),
    .ce  (ce),
    .a   (sel_a),
    .b   (sel_b),
    .p   (rsp_p)
  );

  assign rsp_valid = v2_q;
  assign rsp_id    = id2_q;
  assign inflight  = {1'b0, v1_q} + {1'b0, v2_q};

endmodule

// File: tb/tb_threshold2_mul_arb.sv
// Directed and randomized checks of the shared-multiplier arbiter against a cycle model.
module tb_threshold2_mul_arb;

  localparam int NREQ = 4;
  localparam int A_W  = 20;
  localparam int B_W  = 8;
  localparam int P_W  = 28;
  localparam int ID_W = 2;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [P_W-1:0]      rsp_p;
  logic [ID_W-1:0]     rsp_id;
  logic [1:0]          inflight;

  int tests = 0;
  int fails = 0;
  logic [NREQ-1:0] obs_rdy;

  typedef struct {
    bit     v;
    int     id;
    longint p;
  } op_t;

  op_t    s1, s2;
  int     m_ptr;
  int     wait_cnt [NREQ];
  int     sb_id[$];
  longint sb_p[$];

  threshold2_mul_arb #(
    .NREQ (NREQ),
    .A_W  (A_W),
    .B_W  (B_W),
    .P_W  (P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .inflight  (inflight)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    s1 = '{v: 1'b0, id: 0, p: 0};
    s2 = '{v: 1'b0, id: 0, p: 0};
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    sb_id.delete();
    sb_p.delete();
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*A_W-1:0] a,
                       input logic [NREQ*B_W-1:0] b, input logic rr);
    bit              ce;
    bit              xfer;
    int              win;
    logic [NREQ-1:0] exp_rdy;
    longint          prod;
    prod = 0;
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    #1;
    obs_rdy = req_ready;
    ce  = !(s2.v && !rr);
    win = -1;
    for (int k = 0; k < NREQ; k++)
      if (win < 0 && v[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
    xfer    = ce && (win >= 0);
    exp_rdy = '0;
    if (xfer) exp_rdy[win] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(s2.v));
    chk("inflight", 64'(inflight), 64'(int'(s1.v) + int'(s2.v)));
    if (s2.v) begin
      chk("rsp_p", 64'(rsp_p), 64'(s2.p));
      chk("rsp_id", 64'(rsp_id), 64'(s2.id));
    end
    if (rsp_valid === 1'b1 && rr) begin
      if (sb_id.size() == 0) chk("sb_underflow", 64'(sb_id.size()), 64'd1);
      else begin
        chk("sb_id", 64'(rsp_id), 64'(sb_id.pop_front()));
        chk("sb_p", 64'(rsp_p), 64'(sb_p.pop_front()));
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (xfer && i == win) begin
        chk("starve", 64'(wait_cnt[i] < NREQ), 64'd1);
        wait_cnt[i] = 0;
      end else if (!v[i]) wait_cnt[i] = 0;
      else if (xfer) wait_cnt[i]++;
    end
    if (xfer) prod = longint'(a[win*A_W +: A_W]) * longint'(b[win*B_W +: B_W]);
    @(posedge ap_clk);
    #1;
    if (ce) begin
      s2   = s1;
      s1.v = xfer;
      s1.id = xfer ? win : 0;
      s1.p = prod;
    end
    if (xfer) begin
      sb_id.push_back(win);
      sb_p.push_back(prod);
      m_ptr = (win + 1) % NREQ;
    end
  endtask

  // Assert reset across one posedge; the next cycle() call releases it.
  task automatic do_reset(input logic [NREQ-1:0] v);
    @(negedge ap_clk);
    req_valid = v;
    rsp_ready = 1'b1;
    ap_rst_n  = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    @(posedge ap_clk);
    #1;
    chk("rst_hold_ready", 64'(req_ready), 64'd0);
    model_clear();
  endtask

  initial begin
    logic [NREQ*A_W-1:0] a;
    logic [NREQ*B_W-1:0] b;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_clear();
    do_reset(4'b1111);

    // Single requester, latency 2.
    a = '0;
    b = '0;
    a[0 +: A_W] = 20'd1000;
    b[0 +: B_W] = 8'd200;
    cycle(4'b0001, a, b, 1'b1);
    chk("single_inflight", 64'(inflight), 64'd1);
    chk("single_not_yet", 64'(rsp_valid), 64'd0);
    cycle(4'b0000, a, b, 1'b1);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_p", 64'(rsp_p), 64'd200000);
    chk("single_id", 64'(rsp_id), 64'd0);
    cycle(4'b0000, a, b, 1'b1);

    // Full-width operands on requester 3.
    a[3*A_W +: A_W] = '1;
    b[3*B_W +: B_W] = '1;
    cycle(4'b1000, a, b, 1'b1);
    cycle(4'b0000, a, b, 1'b1);
    chk("max_p", 64'(rsp_p), 64'h0FEFFF01);
    chk("max_id", 64'(rsp_id), 64'd3);
    cycle(4'b0000, a, b, 1'b1);
    cycle(4'b0000, a, b, 1'b1);

    // All requesters held valid: strict rotation, back-to-back responses.
    for (int i = 0; i < NREQ; i++) begin
      a[i*A_W +: A_W] = A_W'(100 + i);
      b[i*B_W +: B_W] = B_W'(3 + i);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, a, b, 1'b1);
      chk("rr_grant", 64'(obs_rdy), 64'd1 << (i % NREQ));
      if (i > 0) begin
        chk("b2b_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_id", 64'(rsp_id), 64'((i - 1) % NREQ));
      end
    end

    // Backpressure: requester 2's product (102*5) must sit still.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, a, b, 1'b0);
      chk("bp_ready", 64'(obs_rdy), 64'd0);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_p", 64'(rsp_p), 64'd510);
      chk("bp_inflight", 64'(inflight), 64'd2);
    end
    for (int i = 0; i < 3; i++) cycle(4'b0000, a, b, 1'b1);
    chk("drain_inflight", 64'(inflight), 64'd0);
    chk("drain_sb", 64'(sb_id.size()), 64'd0);

    // Reset with two operations in flight.
    cycle(4'b0010, a, b, 1'b1);
    cycle(4'b0100, a, b, 1'b1);
    chk("pre_rst_inflight", 64'(inflight), 64'd2);
    do_reset(4'b0000);
    cycle(4'b1111, a, b, 1'b1);
    chk("post_rst_grant", 64'(obs_rdy), 64'd1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, a, b, 1'b1);
    chk("post_rst_sb", 64'(sb_id.size()), 64'd0);
    chk("post_rst_inflight", 64'(inflight), 64'd0);

    // Random traffic and backpressure.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i*A_W +: A_W] = A_W'($urandom);
        b[i*B_W +: B_W] = B_W'($urandom);
      end
      cycle(NREQ'($urandom_range(0, 15)), a, b, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, a, b, 1'b1);
    chk("final_sb", 64'(sb_id.size()), 64'd0);
    chk("final_inflight", 64'(inflight), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
